slice_transposer: RTL

Upstream feeder for the column-parity datapath. It accepts a 1600-bit state as 25 lane words of 64 bits and stores them in a 25×64 bit array, transposing as it writes. It then streams the 64 slices of 25 bits in order, one per handshake. With each slice it also supplies the previous slice, so the downstream curr/pre slice inputs can be fed directly.

---
 rtl/slice_transposer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/slice_transposer.sv
// Lane-to-slice transposer: loads 25 lanes of 64 bits, then streams 64 slices of 25 bits
// alongside the previous slice. Build option: SLICE_TP_WRAP_EN (cyclic pre_slice at index 0).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_LOAD | accepting lane words; each lane fills one bit column of the array
// ST_EMIT | presenting slice r_slice_cnt and its predecessor until accepted
module slice_transposer #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lane_valid,
  output logic             lane_ready,
  input  logic [DEPTH-1:0] lane_data,
  output logic             slice_valid,
  input  logic             slice_ready,
  output logic [WIDTH-1:0] curr_slice,
  output logic [WIDTH-1:0] pre_slice,
  output logic [IDX_W-1:0] slice_index,
  output logic             last_slice,
  output logic             done
);

  localparam int LANE_W = $clog2(WIDTH);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LANE_W-1:0]  r_lane_cnt;
  logic [IDX_W-1:0]   r_slice_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic               w_lane_acc;
  logic               w_slice_acc;
  logic               w_lane_last;
  logic               w_slice_last;
  logic               w_lane_ready;
  logic               w_slice_valid;
  logic [IDX_W-1:0]   w_pre_idx;
  logic [WIDTH-1:0]   w_pre_slice;

  assign w_lane_last  = (r_lane_cnt == LANE_W'(WIDTH - 1));
  assign w_slice_last = (r_slice_cnt == IDX_W'(DEPTH - 1));
  assign w_lane_acc   = lane_valid && w_lane_ready;
  assign w_slice_acc  = slice_ready && w_slice_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lane_ready  = 1'b0;
    w_slice_valid = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_lane_ready = 1'b1;
        if (lane_valid && w_lane_last) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_slice_valid = 1'b1;
        if (slice_ready && w_slice_last) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane_cnt <= '0;
    end else if (w_lane_acc) begin
      r_lane_cnt <= w_lane_last ? '0 : r_lane_cnt + LANE_W'(1);
    end
  end

  // Slice counter wraps naturally since DEPTH == 2**IDX_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slice_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_slice_acc && w_slice_last;
      if (w_slice_acc) begin
        r_slice_cnt <= r_slice_cnt + IDX_W'(1);
      end
    end
  end

  // Lane i lands in bit column i: bit z of the lane goes to slice z.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int z = 0; z < DEPTH; z++) begin
        r_mem[z] <= '0;
      end
    end else if (w_lane_acc) begin
      for (int z = 0; z < DEPTH; z++) begin
        r_mem[z][r_lane_cnt] <= lane_data[z];
      end
    end
  end

  assign w_pre_idx = r_slice_cnt - IDX_W'(1);

`ifdef SLICE_TP_WRAP_EN
  assign w_pre_slice = r_mem[w_pre_idx];
`else
  assign w_pre_slice = (r_slice_cnt == '0) ? '0 : r_mem[w_pre_idx];
`endif

  assign lane_ready  = w_lane_ready;
  assign slice_valid = w_slice_valid;
  assign curr_slice  = r_mem[r_slice_cnt];
  assign pre_slice   = w_pre_slice;
  assign slice_index = r_slice_cnt;
  assign last_slice  = w_slice_valid && w_slice_last;
  assign done        = r_done;

endmodule
